mem_access_unit: RTL and testbench

Memory-side stage directly downstream of the multicycle control FSM. It consumes the memory_read, memory_write and lorD strobes plus the datapath address and store data, and runs one variable-latency req/ack transaction per access on the external memory bus. It handles RV32I byte, halfword and word formatting. It asserts stall so the control FSM holds its current state until the access completes.

---
 rtl/mem_access_unit.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-side stage behind the multicycle control FSM: runs one req/ack bus
// transaction per load, store or fetch, and stalls the FSM until it completes.
module mem_access_unit #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  memory_read,
   input  logic                  memory_write,
   input  logic                  lorD,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           write_data,
   output logic                  stall,
   output logic [31:0]           read_data,
   output logic                  misaligned,
   output logic                  bus_timeout,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [31:0]           bus_wdata,
   output logic [3:0]            bus_be,
   input  logic                  bus_ack,
   input  logic [31:0]           bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [1:0]  SZ_BYTE = 2'b00;
   localparam logic [1:0]  SZ_HALF = 2'b01;
   localparam logic [1:0]  SZ_WORD = 2'b10;
   localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t                r_state;
   state_t                w_nextState;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_be;
   logic [1:0]            r_size;
   logic                  r_unsigned;
   logic [1:0]            r_off;
   logic [15:0]           r_count;
   logic [31:0]           r_readData;
   logic                  r_misaligned;
   logic                  r_timeout;

   logic                  w_start;
   logic                  w_isWrite;
   logic [1:0]            w_size;
   logic                  w_unsigned;
   logic                  w_aligned;
   logic                  w_legal;
   logic [3:0]            w_be;
   logic [31:0]           w_wdata;
   logic                  w_timeoutHit;
   logic                  w_stall;
   logic [31:0]           w_shifted;
   logic [31:0]           w_loadData;

   assign w_start      = memory_read | memory_write;
   assign w_isWrite    = memory_write;
   assign w_legal      = w_start & w_aligned;
   assign w_timeoutHit = (r_count == LP_LAST) & ~bus_ack;

   // Width decode: a fetch is always a word; funct3 codes 011/110/111 fall back to word.
   always_comb begin
      w_size     = SZ_WORD;
      w_unsigned = 1'b0;
      if (lorD) begin
         case (funct3[1:0])
            2'b00:   w_size = SZ_BYTE;
            2'b01:   w_size = SZ_HALF;
            default: w_size = SZ_WORD;
         endcase
         w_unsigned = funct3[2];
      end
   end

   always_comb begin
      w_aligned = 1'b1;
      w_be      = 4'b1111;
      w_wdata   = 32'd0;
      case (w_size)
         SZ_BYTE: w_aligned = 1'b1;
         SZ_HALF: w_aligned = ~address[0];
         default: w_aligned = (address[1:0] == 2'b00);
      endcase
      if (w_isWrite) begin
         case (w_size)
            SZ_BYTE: begin
               w_be    = 4'b0001 << address[1:0];
               w_wdata = {4{write_data[7:0]}};
            end
            SZ_HALF: begin
               w_be    = address[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{write_data[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = write_data;
            end
         endcase
      end
   end

   // Bring the addressed lane down to bit 0, then extend to 32 bits.
   always_comb begin
      w_shifted  = bus_rdata >> {r_off, 3'b000};
      w_loadData = w_shifted;
      case (r_size)
         SZ_BYTE: w_loadData = {{24{~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
         SZ_HALF: w_loadData = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
         default: w_loadData = w_shifted;
      endcase
   end

   always_comb begin
      w_nextState = r_state;
      w_stall     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_stall     = w_legal;
               w_nextState = w_legal ? REQ : DONE;
            end
         end
         REQ: begin
            w_stall = 1'b1;
            if (bus_ack || w_timeoutHit) w_nextState = DONE;
         end
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= 32'd0;
         r_be         <= 4'd0;
         r_size       <= SZ_WORD;
         r_unsigned   <= 1'b0;
         r_off        <= 2'd0;
         r_count      <= 16'd0;
         r_readData   <= 32'd0;
         r_misaligned <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_state      <= w_nextState;
         r_misaligned <= 1'b0;
         r_timeout    <= 1'b0;
         case (r_state)
            IDLE: begin
               r_count <= 16'd0;
               if (w_legal) begin
                  r_we       <= w_isWrite;
                  r_addr     <= {address[ADDR_WIDTH-1:2], 2'b00};
                  r_wdata    <= w_wdata;
                  r_be       <= w_be;
                  r_size     <= w_size;
                  r_unsigned <= w_unsigned;
                  r_off      <= address[1:0];
               end else if (w_start) begin
                  r_misaligned <= 1'b1;
               end
            end
            REQ: begin
               r_count <= r_count + 16'd1;
               if (bus_ack) begin
                  if (!r_we) r_readData <= w_loadData;
               end else if (w_timeoutHit) begin
                  r_timeout <= 1'b1;
                  if (!r_we) r_readData <= 32'd0;
               end
            end
            default: r_count <= 16'd0;
         endcase
      end
   end

   // Stall is gated by reset so the control FSM is released the instant reset asserts.
   assign stall       = w_stall & rst_n;
   assign bus_req     = (r_state == REQ);
   assign bus_we      = r_we;
   assign bus_addr    = r_addr;
   assign bus_wdata   = r_wdata;
   assign bus_be      = r_be;
   assign read_data   = r_readData;
   assign misaligned  = r_misaligned;
   assign bus_timeout = r_timeout;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: fetch, loads, stores,
// misalignment, timeout, strobe priority and asynchronous reset mid-transaction.
module tb_mem_access_unit;

   localparam int TB_TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        memory_read, memory_write, lorD;
   logic [2:0]  funct3;
   logic [31:0] address, write_data;
   logic        stall, misaligned, bus_timeout;
   logic [31:0] read_data;
   logic        bus_req, bus_we, bus_ack;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;

   int checkCount = 0;
   int errorCount = 0;

   int          gStall, gReq, gMis, gTo;
   logic [31:0] gReadData, gBusAddr, gWdata;
   logic [3:0]  gBe;
   logic        gWe;

   mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .memory_read(memory_read), .memory_write(memory_write), .lorD(lorD),
      .funct3(funct3), .address(address), .write_data(write_data),
      .stall(stall), .read_data(read_data), .misaligned(misaligned),
      .bus_timeout(bus_timeout), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   // Hard stop in case a wait goes wrong somewhere unforeseen.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // One access: strobes applied mid-cycle, a simple bus model acks after ackWait
   // extra REQ cycles (negative = never), and the run ends on the first DONE cycle.
   task automatic applyStimulus(input logic rd, input logic wr, input logic ld, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rdat, input int ackWait);
      int   cyc;
      logic done;
      gStall = 0; gReq = 0; gMis = 0; gTo = 0; done = 1'b0; cyc = 0;
      gBusAddr = 32'hx; gBe = 4'hx; gWe = 1'bx; gWdata = 32'hx;
      @(negedge clk);
      memory_read = rd; memory_write = wr; lorD = ld; funct3 = f3;
      address = addr; write_data = wd; bus_rdata = rdat; bus_ack = 1'b0;
      while (!done && cyc < 40) begin
         #1;
         if (misaligned)  gMis++;
         if (bus_timeout) gTo++;
         if (cyc > 0 && !stall) begin
            done      = 1'b1;
            gReadData = read_data;
            bus_ack   = 1'b0;
         end else begin
            if (stall) gStall++;
            if (bus_req) begin
               gReq++;
               if (gReq == 1) begin
                  gBusAddr = bus_addr; gBe = bus_be; gWe = bus_we; gWdata = bus_wdata;
               end
               bus_ack = (ackWait >= 0) && (gReq == ackWait + 1);
            end else begin
               bus_ack = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      checkOutput("access_completes", 32'(done), 32'd1);
      @(posedge clk);
      #1;
      memory_read = 1'b0; memory_write = 1'b0; bus_ack = 1'b0;
      if (misaligned)  gMis++;
      if (bus_timeout) gTo++;
   endtask

   initial begin
      rst_n = 1'b0; memory_read = 1'b0; memory_write = 1'b0; lorD = 1'b0;
      funct3 = 3'b000; address = 32'd0; write_data = 32'd0;
      bus_ack = 1'b0; bus_rdata = 32'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rst_stall", 32'(stall), 32'd0);
      checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
      checkOutput("rst_bus_we", 32'(bus_we), 32'd0);
      checkOutput("rst_bus_addr", bus_addr, 32'd0);
      checkOutput("rst_bus_wdata", bus_wdata, 32'd0);
      checkOutput("rst_bus_be", 32'(bus_be), 32'd0);
      checkOutput("rst_read_data", read_data, 32'd0);
      checkOutput("rst_flags", {30'd0, misaligned, bus_timeout}, 32'd0);

      // Fetch with funct3 = byte to show it is ignored; ack on the third REQ cycle.
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0010, 32'd0, 32'h0050_0093, 2);
      checkOutput("fetch_stall_cycles", 32'(gStall), 32'd4);
      checkOutput("fetch_req_cycles", 32'(gReq), 32'd3);
      checkOutput("fetch_be", 32'(gBe), 32'h0000_000F);
      checkOutput("fetch_we", 32'(gWe), 32'd0);
      checkOutput("fetch_addr", gBusAddr, 32'h0000_0010);
      checkOutput("fetch_data", gReadData, 32'h0050_0093);

      applyStimulus(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'd0, 32'h80AA_BBCC, 0);
      checkOutput("lb_stall_cycles", 32'(gStall), 32'd2);
      checkOutput("lb_addr", gBusAddr, 32'h0000_0100);
      checkOutput("lb_be", 32'(gBe), 32'h0000_000F);
      checkOutput("lb_data", gReadData, 32'hFFFF_FF80);

      applyStimulus(1'b1, 1'b0, 1'b1, 3'b100, 32'h0000_0103, 32'd0, 32'h80AA_BBCC, 0);
      checkOutput("lbu_data", gReadData, 32'h0000_0080);

      applyStimulus(1'b0, 1'b1, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'hDEAD_BEEF, 0);
      checkOutput("sh_addr", gBusAddr, 32'h0000_0200);
      checkOutput("sh_be", 32'(gBe), 32'h0000_000C);
      checkOutput("sh_wdata", gWdata, 32'hABCD_ABCD);
      checkOutput("sh_we", 32'(gWe), 32'd1);
      checkOutput("sh_read_data_held", gReadData, 32'h0000_0080);

      applyStimulus(1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0305, 32'h0000_005A, 32'd0, 1);
      checkOutput("sb_be", 32'(gBe), 32'h0000_0002);
      checkOutput("sb_wdata", gWdata, 32'h5A5A_5A5A);
      checkOutput("sb_addr", gBusAddr, 32'h0000_0304);

      applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'd0, 32'h5555_5555, 0);
      checkOutput("mis_pulses", 32'(gMis), 32'd1);
      checkOutput("mis_req_cycles", 32'(gReq), 32'd0);
      checkOutput("mis_stall_cycles", 32'(gStall), 32'd0);
      checkOutput("mis_read_data_held", gReadData, 32'h0000_0080);

      applyStimulus(1'b1, 1'b0, 1'b1, 3'b101, 32'h0000_0102, 32'd0, 32'hF00D_0000, 0);
      checkOutput("lhu_mis_pulses", 32'(gMis), 32'd0);
      checkOutput("lhu_data", gReadData, 32'h0000_F00D);

      applyStimulus(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0100, 32'd0, 32'h1234_8001, 0);
      checkOutput("lh_data", gReadData, 32'hFFFF_8001);

      applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'd0, 32'h7777_7777, -1);
      checkOutput("to_req_cycles", 32'(gReq), 32'd4);
      checkOutput("to_stall_cycles", 32'(gStall), 32'd5);
      checkOutput("to_pulses", 32'(gTo), 32'd1);
      checkOutput("to_read_data", gReadData, 32'd0);

      applyStimulus(1'b1, 1'b1, 1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h1111_1111, 0);
      checkOutput("both_we", 32'(gWe), 32'd1);
      checkOutput("both_wdata", gWdata, 32'hCAFE_F00D);
      checkOutput("both_be", 32'(gBe), 32'h0000_000F);
      checkOutput("both_read_data_held", gReadData, 32'd0);

      // Asynchronous reset in the middle of a REQ phase, then a stray ack.
      @(negedge clk);
      memory_read = 1'b1; lorD = 1'b0; address = 32'h0000_0500; bus_rdata = 32'h9999_9999;
      @(negedge clk);
      #1;
      checkOutput("arst_pre_req", 32'(bus_req), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_req_drop", 32'(bus_req), 32'd0);
      checkOutput("arst_stall_drop", 32'(stall), 32'd0);
      memory_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      checkOutput("late_ack_read_data", read_data, 32'd0);
      checkOutput("late_ack_bus_req", 32'(bus_req), 32'd0);

      applyStimulus(1'b1, 1'b0, 1'b0, 3'b111, 32'h0000_0020, 32'd0, 32'h00A0_0113, 0);
      checkOutput("post_rst_stall_cycles", 32'(gStall), 32'd2);
      checkOutput("post_rst_data", gReadData, 32'h00A0_0113);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
